// File: rtl/des_cbc_sequencer.sv
// des_cbc_sequencer: block-mode front end for DES_core with CBC chaining and a completion watchdog.
// Build option: define DES_CBC_EN for CBC chaining; the default build is ECB only.
module des_cbc_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic        cbc_mode,
    input  logic [63:0] key_in,
    input  logic [63:0] iv_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        des_encipher_en,
    output logic        des_decipher_en,
    output logic [63:0] des_data,
    output logic [63:0] des_key_in,
    input  logic        desc_ready,
    input  logic [63:0] desc_result,
    output logic        busy,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    // Handshakes: a beat transfers on any rising clk edge where valid && ready.
    // in_ready is high only in LOAD and out_valid only in OUTPUT, so they never overlap;
    // out_data/out_last stay frozen while out_valid waits for out_ready.

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    // Last watchdog value checked in WAIT; timeout_err becomes visible TIMEOUT_CYCLES after launch.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]      state;
    logic [63:0]     key_q;
    logic [63:0]     des_data_q;
    logic [63:0]     res_q;
    logic            res_last_q;
    logic            dec_q;
    logic            last_q;
    logic            rdy_q;
    logic            terr_q;
    logic [TO_W-1:0] wd_q;
    logic [63:0]     chain_mask;
    logic            core_done;
    logic [63:0]     load_data;
    logic [63:0]     res_next;

    assign core_done = desc_ready && !rdy_q;

`ifdef DES_CBC_EN
    logic        cbc_q;
    logic [63:0] chain_q;

    assign chain_mask = cbc_q ? chain_q : 64'd0;

    // In decipher the captured ciphertext is des_data_q itself, so it becomes the next chain value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cbc_q   <= 1'b0;
            chain_q <= 64'd0;
        end else if (state == S_IDLE && start) begin
            cbc_q   <= cbc_mode;
            chain_q <= iv_in;
        end else if (state == S_WAIT && core_done) begin
            chain_q <= dec_q ? des_data_q : desc_result;
        end
    end
`else
    logic unused_cbc;
    assign unused_cbc = ^{cbc_mode, iv_in};
    assign chain_mask = 64'd0;
`endif

    always_comb begin
        load_data = in_data;
        res_next  = desc_result;
        if (!dec_q) begin
            load_data = in_data ^ chain_mask;
        end else begin
            res_next = desc_result ^ chain_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            key_q      <= 64'd0;
            des_data_q <= 64'd0;
            res_q      <= 64'd0;
            res_last_q <= 1'b0;
            dec_q      <= 1'b0;
            last_q     <= 1'b0;
            rdy_q      <= 1'b0;
            terr_q     <= 1'b0;
            wd_q       <= '0;
        end else begin
            rdy_q <= desc_ready;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q  <= key_in;
                        dec_q  <= decrypt;
                        terr_q <= 1'b0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        des_data_q <= load_data;
                        last_q     <= in_last;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_q  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion edge wins over a watchdog expiry in the same cycle.
                    if (core_done) begin
                        res_q      <= res_next;
                        res_last_q <= last_q;
                        state      <= S_OUTPUT;
                    end else if (wd_q == TO_LAST) begin
                        terr_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        state <= last_q ? S_IDLE : S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready        = (state == S_LOAD);
    assign out_valid       = (state == S_OUTPUT);
    assign out_data        = res_q;
    assign out_last        = res_last_q;
    assign des_encipher_en = (state == S_LAUNCH) && !dec_q;
    assign des_decipher_en = (state == S_LAUNCH) && dec_q;
    assign des_data        = des_data_q;
    assign des_key_in      = key_q;
    assign busy            = (state != S_IDLE);
    assign timeout_err     = terr_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_des_cbc_sequencer.sv
// Self-checking bench for des_cbc_sequencer: toy XOR core model, CBC/ECB reference model, scenario tasks.
module tb_des_cbc_sequencer;

    localparam int          T      = 64;
    localparam logic [63:0] K      = 64'h7CA1_1045_4A1A_6E57;
    localparam logic [63:0] P0     = 64'hD4B6_9021_8FAE_C377;
    localparam logic [63:0] P1     = 64'hDBE2_057A_420E_C6EF;
    localparam logic [63:0] C_ECB  = 64'hA817_8064_C5B4_AD20;
    localparam logic [63:0] C_CBC0 = 64'hA817_8064_C5B4_AD21;
    localparam logic [63:0] C_CBC1 = 64'h0F54_955B_CDA0_0599;

    logic        clk, rst, start, decrypt, cbc_mode;
    logic [63:0] key_in, iv_in, in_data, out_data, des_data, des_key_in, desc_result;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic        des_encipher_en, des_decipher_en, desc_ready, busy, timeout_err;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [64:0] exp_q[$];
    logic [63:0] m_key, m_chain;
    logic        m_dec, m_cbc;

    // 0 = normal core, 1 = never completes, 2 = completion level stuck high
    int core_mode = 0;
    int core_cnt;

    int   neg_idx = 0, enc_pulses = 0, dec_pulses = 0, long_pulses = 0, both_cnt = 0;
    int   overlap_cnt = 0, rdy_rise_idx = 0, launch_idx = 0, te_rise_idx = 0;
    int   ov_rises = 0, lat_bad = 0;
    logic prev_en = 0, prev_rdy = 0, prev_ov = 0, prev_te = 0;

    des_cbc_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .cbc_mode(cbc_mode),
        .key_in(key_in), .iv_in(iv_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .des_encipher_en(des_encipher_en), .des_decipher_en(des_decipher_en),
        .des_data(des_data), .des_key_in(des_key_in),
        .desc_ready(desc_ready), .desc_result(desc_result),
        .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- toy DES core: result = data ^ key ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_ready  <= 1'b1;
            desc_result <= 64'd0;
            core_cnt    <= 0;
        end else if (core_mode == 2) begin
            desc_ready <= 1'b1;
            core_cnt   <= 0;
        end else if (des_encipher_en || des_decipher_en) begin
            desc_ready  <= 1'b0;
            desc_result <= des_data ^ des_key_in;
            core_cnt    <= 3;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && core_mode == 0) desc_ready <= 1'b1;
        end
    end

    // ---------------- event monitor ----------------
    always @(negedge clk) begin
        neg_idx = neg_idx + 1;
        if (des_encipher_en) enc_pulses = enc_pulses + 1;
        if (des_decipher_en) dec_pulses = dec_pulses + 1;
        if (des_encipher_en && des_decipher_en) both_cnt = both_cnt + 1;
        if ((des_encipher_en || des_decipher_en) && prev_en) long_pulses = long_pulses + 1;
        if (des_encipher_en || des_decipher_en) launch_idx = neg_idx;
        if (in_ready && out_valid) overlap_cnt = overlap_cnt + 1;
        if (desc_ready === 1'b1 && prev_rdy === 1'b0) rdy_rise_idx = neg_idx;
        if (out_valid === 1'b1 && prev_ov === 1'b0) begin
            ov_rises = ov_rises + 1;
            if (neg_idx - rdy_rise_idx != 1) lat_bad = lat_bad + 1;
        end
        if (timeout_err === 1'b1 && prev_te === 1'b0) te_rise_idx = neg_idx;
        prev_en  = des_encipher_en || des_decipher_en;
        prev_rdy = desc_ready;
        prev_ov  = out_valid;
        prev_te  = timeout_err;
    end

    // ---------------- reference model ----------------
    task automatic model_push(input logic [63:0] p, input logic last);
        logic [63:0] r;
        if (!m_dec) begin
            r       = (p ^ (m_cbc ? m_chain : 64'd0)) ^ m_key;
            m_chain = r;
        end else begin
            r       = (p ^ m_key) ^ (m_cbc ? m_chain : 64'd0);
            m_chain = p;
        end
        exp_q.push_back({last, r});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic dec, input logic cbc, input logic [63:0] key,
                            input logic [63:0] iv);
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_idle: busy=%b required 0", busy);
        end
        start = 1'b1; decrypt = dec; cbc_mode = cbc; key_in = key; iv_in = iv;
        @(negedge clk);
        start    = 1'b0;
        decrypt  = 1'($urandom);
        cbc_mode = 1'($urandom);
        key_in   = {$urandom, $urandom};
        iv_in    = {$urandom, $urandom};
        m_key = key; m_dec = dec; m_chain = iv;
`ifdef DES_CBC_EN
        m_cbc = cbc;
`else
        m_cbc = 1'b0;
`endif
    endtask

    task automatic send_block(input logic [63:0] p, input logic last, input logic push);
        int guard = 0;
        if (push) model_push(p, last);
        in_valid = 1'b1; in_data = p; in_last = last;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL in_accept: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
    endtask

    task automatic recv_block(input string name, input int delay, output logic [63:0] got);
        int          guard = 0;
        logic [64:0] exp;
        got = 64'd0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: out_valid=%b required 1", name, out_valid);
            return;
        end
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'bx;
        got = out_data;
        n_cmp++;
        if ({out_last, out_data} !== exp) begin
            n_bad++;
            $display("FAIL %s_data: got last=%b data=%h required last=%b data=%h",
                     name, out_last, out_data, exp[64], exp[63:0]);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        n_cmp++;
        if ({busy, in_ready, out_valid, out_last, des_encipher_en, des_decipher_en, timeout_err,
             des_data, des_key_in, out_data, state_dbg} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b in_ready=%b out_valid=%b des_data=%h key=%h out_data=%h state=%0d required all 0",
                     busy, in_ready, out_valid, des_data, des_key_in, out_data, state_dbg);
        end
    endtask

    task automatic test_ecb_encipher;
        logic [63:0] got;
        do_start(1'b0, 1'b0, K, 64'd0);
        n_cmp++;
        if (des_key_in !== K) begin
            n_bad++;
            $display("FAIL ecb_key: des_key_in=%h required %h", des_key_in, K);
        end
        send_block(P0, 1'b1, 1'b1);
        recv_block("ecb", 0, got);
        n_cmp++;
        if (got !== C_ECB) begin
            n_bad++;
            $display("FAIL ecb_vector: got %h required %h", got, C_ECB);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ecb_busy_fall: busy=%b required 0", busy);
        end
    endtask

    task automatic test_cbc_round_trip;
        logic [63:0] c0, c1, d0, d1;
        int          e0, q0;
        do_start(1'b0, 1'b1, K, 64'd1);
        send_block(P0, 1'b0, 1'b1);
        recv_block("cbc_enc0", 0, c0);
        send_block(P1, 1'b1, 1'b1);
        recv_block("cbc_enc1", 0, c1);
`ifdef DES_CBC_EN
        n_cmp++;
        if (c0 !== C_CBC0 || c1 !== C_CBC1) begin
            n_bad++;
            $display("FAIL cbc_vector: got %h %h required %h %h", c0, c1, C_CBC0, C_CBC1);
        end
`endif
        e0 = enc_pulses; q0 = dec_pulses;
        do_start(1'b1, 1'b1, K, 64'd1);
        send_block(c0, 1'b0, 1'b1);
        recv_block("cbc_dec0", 1, d0);
        send_block(c1, 1'b1, 1'b1);
        recv_block("cbc_dec1", 2, d1);
        n_cmp++;
        if (d0 !== P0 || d1 !== P1) begin
            n_bad++;
            $display("FAIL cbc_decipher: got %h %h required %h %h", d0, d1, P0, P1);
        end
        n_cmp++;
        if (enc_pulses - e0 != 0 || dec_pulses - q0 != 2) begin
            n_bad++;
            $display("FAIL cbc_dec_pulses: enc=%0d dec=%0d required 0 and 2",
                     enc_pulses - e0, dec_pulses - q0);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] d0, got;
        int          p0, guard;
        do_start(1'b0, 1'b1, K, {$urandom, $urandom});
        send_block({$urandom, $urandom}, 1'b0, 1'b1);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        d0 = out_data;
        p0 = enc_pulses + dec_pulses;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1; key_in = ~K; decrypt = 1'b1;
            end else begin
                start = 1'b0;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_data=%h required 1 0 %h",
                         i, out_valid, in_ready, out_data, d0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (enc_pulses + dec_pulses != p0 || des_key_in !== K) begin
            n_bad++;
            $display("FAIL bp_quiet: pulses=%0d key=%h required %0d %h",
                     enc_pulses + dec_pulses, des_key_in, p0, K);
        end
        recv_block("bp0", 0, got);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next_load: in_ready=%b busy=%b required 1 1", in_ready, busy);
        end
        send_block({$urandom, $urandom}, 1'b1, 1'b1);
        recv_block("bp1", 0, got);
    endtask

    task automatic wait_timeout(input string name);
        int guard = 0;
        while (timeout_err !== 1'b1 && guard < T + 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b1 || te_rise_idx - launch_idx != T) begin
            n_bad++;
            $display("FAIL %s_timing: timeout_err=%b delay=%0d required 1 after %0d",
                     name, timeout_err, te_rise_idx - launch_idx, T);
        end
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b out_valid=%b required 0 0", name, busy, out_valid);
        end
    endtask

    task automatic test_timeout;
        logic [63:0] got;
        int          ov0;
        ov0 = ov_rises;
        core_mode = 1;
        do_start(1'b0, 1'b0, K, 64'd0);
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        wait_timeout("to_hang");
        core_mode = 2;
        repeat (2) @(negedge clk);
        do_start(1'b1, 1'b1, K, 64'd0);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_clear_on_start: timeout_err=%b required 0", timeout_err);
        end
        send_block({$urandom, $urandom}, 1'b1, 1'b0);
        wait_timeout("to_level_high");
        n_cmp++;
        if (ov_rises != ov0) begin
            n_bad++;
            $display("FAIL to_no_output: out_valid rises=%0d required 0", ov_rises - ov0);
        end
        core_mode = 0;
        do_start(1'b0, 1'b0, K, 64'd0);
        send_block(P0, 1'b1, 1'b1);
        recv_block("to_recover", 0, got);
        n_cmp++;
        if (got !== C_ECB || timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_recover_vec: got %h terr=%b required %h 0", got, timeout_err, C_ECB);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] got;
        int          guard, ov0;
        do_start(1'b0, 1'b0, K, 64'd0);
        send_block({$urandom, $urandom}, 1'b1, 1'b1);
        guard = 0;
        while (des_encipher_en !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        ov0 = ov_rises;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (ov_rises != ov0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_discard: out_valid rises=%0d busy=%b required 0 0", ov_rises - ov0, busy);
        end
        do_start(1'b0, 1'b0, K, 64'd0);
        send_block(P0, 1'b0, 1'b1);
        recv_block("rst_fresh0", 0, got);
        send_block(P1, 1'b1, 1'b1);
        recv_block("rst_fresh1", 0, got);
    endtask

    task automatic test_random;
        logic [63:0] got, key;
        int          len;
        for (int s = 0; s < 6; s++) begin
            key = {$urandom, $urandom};
            do_start(1'($urandom), 1'($urandom), key, {$urandom, $urandom});
            n_cmp++;
            if (des_key_in !== key) begin
                n_bad++;
                $display("FAIL rnd_key[%0d]: des_key_in=%h required %h", s, des_key_in, key);
            end
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                send_block({$urandom, $urandom}, 1'(b == len - 1), 1'b1);
                recv_block("rnd", $urandom_range(0, 3), got);
            end
        end
    endtask

    task automatic test_invariants;
        n_cmp++;
        if (overlap_cnt != 0 || long_pulses != 0 || both_cnt != 0) begin
            n_bad++;
            $display("FAIL invariants: overlap=%0d long_pulses=%0d both=%0d required 0 0 0",
                     overlap_cnt, long_pulses, both_cnt);
        end
        n_cmp++;
        if (lat_bad != 0 || ov_rises == 0) begin
            n_bad++;
            $display("FAIL latency: bad=%0d outputs=%0d required 0 bad", lat_bad, ov_rises);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; cbc_mode = 1'b0;
        key_in = 64'd0; iv_in = 64'd0; in_valid = 1'b0; in_data = 64'd0; in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_ecb_encipher();
        test_cbc_round_trip();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
